serial_tx: RTL

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 70 +++++++
 1 files changed

// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial transmitter with a valid/ready input and back-to-back framing.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit to each frame.
module serial_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last
);
    localparam int CW = $clog2(WIDTH) + 1;
`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif
    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             w_end, w_acc, w_bit;
    assign w_end      = r_state == SHIFT && r_cnt == CW'(WIDTH - 1);
    assign w_bit      = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign din_ready  = r_state == IDLE || last;
    assign w_acc      = din_valid && din_ready;
    assign sout_valid = r_state != IDLE;
`ifdef SERIAL_TX_PARITY_EN
    logic r_par;
    assign last = r_state == PARITY;
    assign sout = r_state == SHIFT ? w_bit : (r_state == PARITY ? r_par : 1'b1);
`else
    assign last = w_end;
    assign sout = r_state == SHIFT ? w_bit : 1'b1;
`endif
    // Acceptance is only possible in IDLE or on the final bit, so it always restarts SHIFT.
    always_comb begin
        w_next = r_state;
`ifdef SERIAL_TX_PARITY_EN
        w_next = w_acc ? SHIFT : (r_state == SHIFT ? (w_end ? PARITY : SHIFT) : IDLE);
`else
        w_next = w_acc ? SHIFT : (r_state == SHIFT && !w_end ? SHIFT : IDLE);
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_acc) begin
            r_cnt   <= '0;
            r_shift <= din;
        end else if (r_state == SHIFT) begin
            r_cnt   <= r_cnt + CW'(1);
            r_shift <= MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
        end
    end
`ifdef SERIAL_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_par <= 1'b0;
        else if (w_acc) r_par <= ^din;
    end
`endif
endmodule
